// File: rtl/ins_fetch_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ins_fetch_seq                                                   |
// | Purpose  : Instruction fetch sequencer for the 12-bit soft-core program    |
// |            ROM. Owns the PC, registers fetched words into an instruction   |
// |            register handed out over valid/ready, and executes jump, call   |
// |            and return redirects through an internal return-address stack.  |
// | Ports    : clk, rst_n          clock, async active-low reset              |
// |            start, halt         control (start pulse, halt level)          |
// |            rom_addr, rom_data  program ROM interface (combinational read) |
// |            ir, ir_pc, ir_valid instruction register toward the decoder    |
// |            ir_ready            decoder accepts ir                         |
// |            br_jump/call/ret,   redirect request for the accepted          |
// |            br_target           instruction                                |
// |            sp_level            return-stack occupancy                     |
// |            busy, fault,        status (RUN, sticky stack fault + code)    |
// |            fault_code                                                     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module ins_fetch_seq #(
  parameter int AW          = 11,
  parameter int DW          = 12,
  parameter int STACK_DEPTH = 8,
  parameter int RESET_PC    = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          halt,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic [DW-1:0] ir,
  output logic [AW-1:0] ir_pc,
  output logic          ir_valid,
  input  logic          ir_ready,
  input  logic          br_jump,
  input  logic          br_call,
  input  logic          br_ret,
  input  logic [AW-1:0] br_target,
  output logic [3:0]    sp_level,
  output logic          busy,
  output logic          fault,
  output logic [1:0]    fault_code
);

  // Occupancy counter must represent 0..STACK_DEPTH inclusive.
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int IW  = $clog2(STACK_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_HALT  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t           state, state_d;
  logic [AW-1:0]    pc, pc_d;
  logic [DW-1:0]    ir_d;
  logic [AW-1:0]    ir_pc_d;
  logic             ir_valid_d;
  logic [SPW-1:0]   sp, sp_d;
  logic             fault_d;
  logic [1:0]       fault_code_d;
  logic             push;
  logic             accept;
  logic [AW-1:0]    ret_addr;
  logic [AW-1:0]    stack [STACK_DEPTH];

  assign accept   = ir_valid && ir_ready;
  assign ret_addr = ir_pc + AW'(1);   // wraps modulo 2^AW

  assign rom_addr   = pc;
  assign busy       = (state == S_RUN);
  assign sp_level   = 4'(sp);

  // Next-state and datapath decision. Priority inside RUN:
  // halt > return > call > jump > fetch > hold.
  always_comb begin
    state_d      = state;
    pc_d         = pc;
    ir_d         = ir;
    ir_pc_d      = ir_pc;
    ir_valid_d   = ir_valid;
    sp_d         = sp;
    fault_d      = fault;
    fault_code_d = fault_code;
    push         = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end

      S_RUN: begin
        if (halt) begin
          state_d    = S_HALT;
          ir_valid_d = 1'b0;
        end else if (accept && br_ret) begin
          if (sp == '0) begin
            state_d      = S_FAULT;
            fault_d      = 1'b1;
            fault_code_d = 2'b10;
            ir_valid_d   = 1'b0;
          end else begin
            pc_d       = stack[IW'(sp - SPW'(1))];
            sp_d       = sp - SPW'(1);
            ir_valid_d = 1'b0;
          end
        end else if (accept && br_call) begin
          if (sp == SPW'(STACK_DEPTH)) begin
            state_d      = S_FAULT;
            fault_d      = 1'b1;
            fault_code_d = 2'b01;
            ir_valid_d   = 1'b0;
          end else begin
            push       = 1'b1;
            sp_d       = sp + SPW'(1);
            pc_d       = br_target;
            ir_valid_d = 1'b0;
          end
        end else if (accept && br_jump) begin
          pc_d       = br_target;
          ir_valid_d = 1'b0;
        end else if (!ir_valid || ir_ready) begin
          ir_d       = rom_data;
          ir_pc_d    = pc;
          ir_valid_d = 1'b1;
          pc_d       = pc + AW'(1);
        end
      end

      default: ;  // HALT and FAULT are terminal until reset
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= AW'(RESET_PC);
      ir         <= '0;
      ir_pc      <= '0;
      ir_valid   <= 1'b0;
      sp         <= '0;
      fault      <= 1'b0;
      fault_code <= 2'b00;
    end else begin
      state      <= state_d;
      pc         <= pc_d;
      ir         <= ir_d;
      ir_pc      <= ir_pc_d;
      ir_valid   <= ir_valid_d;
      sp         <= sp_d;
      fault      <= fault_d;
      fault_code <= fault_code_d;
    end
  end

  // Stack storage carries no reset; occupancy alone defines which entries
  // are meaningful.
  always_ff @(posedge clk) begin
    if (push) stack[IW'(sp)] <= ret_addr;
  end

endmodule
`default_nettype wire

// File: tb/tb_ins_fetch_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ins_fetch_seq                                                |
// | Purpose  : Self-checking bench for ins_fetch_seq. Each scenario task       |
// |            pushes the instruction addresses it expects the decoder to     |
// |            consume; a monitor pops and compares on every handshake.       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_ins_fetch_seq;

  localparam int AW = 11;
  localparam int DW = 12;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          halt;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic [DW-1:0] ir;
  logic [AW-1:0] ir_pc;
  logic          ir_valid;
  logic          ir_ready;
  logic          br_jump;
  logic          br_call;
  logic          br_ret;
  logic [AW-1:0] br_target;
  logic [3:0]    sp_level;
  logic          busy;
  logic          fault;
  logic [1:0]    fault_code;

  int tests = 0;
  int fails = 0;
  logic [AW-1:0] exp_q[$];

  ins_fetch_seq #(.AW(AW), .DW(DW), .STACK_DEPTH(8), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .br_jump(br_jump), .br_call(br_call), .br_ret(br_ret), .br_target(br_target),
    .sp_level(sp_level), .busy(busy), .fault(fault), .fault_code(fault_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: two fixed words at 0/1, a distinct pattern elsewhere.
  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    case (a)
      11'd0:   rom_f = 12'hA01;
      11'd1:   rom_f = 12'h063;
      default: rom_f = {1'b0, a} ^ 12'h5A5;
    endcase
  endfunction

  assign rom_data = rom_f(rom_addr);

  // Scoreboard: every handshake must consume the next expected address.
  always @(negedge clk) begin
    if (rst_n && ir_valid && ir_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: consumed ir_pc=%0d with nothing expected", ir_pc);
      end else begin
        logic [AW-1:0] e;
        e = exp_q.pop_front();
        if (ir_pc !== e || ir !== rom_f(e)) begin
          fails++;
          $display("FAIL sb_consume: got ir_pc=%0d ir=%h want ir_pc=%0d ir=%h", ir_pc, ir, e, rom_f(e));
        end
      end
    end
  end

  // Inputs change 1 time unit after the active edge; outputs read there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    tests++;
    if (fault !== 1'b0 || fault_code !== 2'b00 || sp_level !== 4'd0 || busy !== 1'b0 || ir_valid !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: got fault=%0b code=%0b sp=%0d busy=%0b v=%0b want 0/00/0/0/0",
               fault, fault_code, sp_level, busy, ir_valid);
    end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; halt = 0; ir_ready = 0;
    br_jump = 0; br_call = 0; br_ret = 0; br_target = '0;
    step(); step();
    tests++;
    if (ir !== 12'h000 || ir_pc !== 11'd0 || ir_valid !== 1'b0 || rom_addr !== 11'd0 ||
        sp_level !== 4'd0 || busy !== 1'b0 || fault !== 1'b0 || fault_code !== 2'b00) begin
      fails++;
      $display("FAIL reset_values: got ir=%h pc=%0d v=%0b addr=%0d sp=%0d busy=%0b f=%0b code=%0b want all zero",
               ir, ir_pc, ir_valid, rom_addr, sp_level, busy, fault, fault_code);
    end
    rst_n = 1'b1;
    step(); step(); step();
    tests++;
    if (busy !== 1'b0 || ir_valid !== 1'b0 || rom_addr !== 11'd0) begin
      fails++;
      $display("FAIL idle_hold: got busy=%0b v=%0b addr=%0d want 0/0/0", busy, ir_valid, rom_addr);
    end
  endtask

  task automatic test_fetch();
    exp_q.push_back(11'd0);
    exp_q.push_back(11'd1);
    ir_ready = 1; start = 1;
    step();
    start = 0;
    tests++;
    if (busy !== 1'b1 || ir_valid !== 1'b0) begin
      fails++;
      $display("FAIL fetch_latency: got busy=%0b v=%0b want busy=1 v=0", busy, ir_valid);
    end
    step();
    tests++;
    if (ir_valid !== 1'b1 || ir_pc !== 11'd0 || ir !== 12'hA01) begin
      fails++;
      $display("FAIL fetch_first: got v=%0b pc=%0d ir=%h want 1/0/a01", ir_valid, ir_pc, ir);
    end
    step();
    tests++;
    if (ir_valid !== 1'b1 || ir_pc !== 11'd1 || ir !== 12'h063 || busy !== 1'b1) begin
      fails++;
      $display("FAIL fetch_second: got v=%0b pc=%0d ir=%h busy=%0b want 1/1/063/1", ir_valid, ir_pc, ir, busy);
    end
    step();
    ir_ready = 0;   // park with address 2 in ir
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (ir_valid !== 1'b1 || ir_pc !== 11'd2 || ir !== rom_f(11'd2) || rom_addr !== 11'd3) begin
        fails++;
        $display("FAIL bp_hold%0d: got v=%0b pc=%0d ir=%h addr=%0d want 1/2/%h/3",
                 i, ir_valid, ir_pc, ir, rom_addr, rom_f(11'd2));
      end
    end
    exp_q.push_back(11'd2);
    ir_ready = 1;
    step();
    ir_ready = 0;
    tests++;
    if (ir_valid !== 1'b1 || ir_pc !== 11'd3 || ir !== rom_f(11'd3)) begin
      fails++;
      $display("FAIL bp_resume: got v=%0b pc=%0d ir=%h want 1/3/%h", ir_valid, ir_pc, ir, rom_f(11'd3));
    end
  endtask

  task automatic test_jump();
    exp_q.push_back(11'd3); exp_q.push_back(11'd4);
    exp_q.push_back(11'd5); exp_q.push_back(11'd40);
    ir_ready = 1;
    step(); step();   // ir_pc 5 now presented
    br_jump = 1; br_target = 11'd40;
    step();
    br_jump = 0;
    tests++;
    if (ir_valid !== 1'b0 || rom_addr !== 11'd40) begin
      fails++;
      $display("FAIL jump_bubble: got v=%0b addr=%0d want 0/40", ir_valid, rom_addr);
    end
    step();
    tests++;
    if (ir_valid !== 1'b1 || ir_pc !== 11'd40) begin
      fails++;
      $display("FAIL jump_target: got v=%0b pc=%0d want 1/40", ir_valid, ir_pc);
    end
    step();
    ir_ready = 0;
    tests++;
    if (ir_pc !== 11'd41 || sp_level !== 4'd0) begin
      fails++;
      $display("FAIL jump_next: got pc=%0d sp=%0d want 41/0", ir_pc, sp_level);
    end
  endtask

  task automatic test_call_ret();
    exp_q.push_back(11'd41); exp_q.push_back(11'd33); exp_q.push_back(11'd84);
    ir_ready = 1; br_jump = 1; br_target = 11'd33;
    step();
    br_jump = 0;
    step();   // ir_pc 33 presented
    br_call = 1; br_target = 11'd84;
    step();
    br_call = 0;
    tests++;
    if (sp_level !== 4'd1 || ir_valid !== 1'b0 || rom_addr !== 11'd84) begin
      fails++;
      $display("FAIL call_push: got sp=%0d v=%0b addr=%0d want 1/0/84", sp_level, ir_valid, rom_addr);
    end
    step();
    tests++;
    if (ir_pc !== 11'd84 || ir_valid !== 1'b1) begin
      fails++;
      $display("FAIL call_target: got pc=%0d v=%0b want 84/1", ir_pc, ir_valid);
    end
    br_ret = 1;
    step();
    br_ret = 0;
    tests++;
    if (sp_level !== 4'd0 || ir_valid !== 1'b0 || rom_addr !== 11'd34) begin
      fails++;
      $display("FAIL ret_pop: got sp=%0d v=%0b addr=%0d want 0/0/34", sp_level, ir_valid, rom_addr);
    end
    step();
    ir_ready = 0;
    tests++;
    if (ir_pc !== 11'd34 || ir_valid !== 1'b1) begin
      fails++;
      $display("FAIL ret_target: got pc=%0d v=%0b want 34/1", ir_pc, ir_valid);
    end
  endtask

  task automatic test_overflow();
    exp_q.push_back(11'd34);
    for (int i = 0; i < 8; i++) exp_q.push_back(11'(100 + 10 * i));
    ir_ready = 1;
    for (int i = 0; i < 8; i++) begin
      br_call = 1; br_target = 11'(100 + 10 * i);
      step();
      br_call = 0;
      step();
      tests++;
      if (sp_level !== 4'(i + 1) || ir_pc !== 11'(100 + 10 * i)) begin
        fails++;
        $display("FAIL nest_call%0d: got sp=%0d pc=%0d want %0d/%0d", i, sp_level, ir_pc, i + 1, 100 + 10 * i);
      end
    end
    br_call = 1; br_target = 11'd500;
    step();
    br_call = 0;
    tests++;
    if (fault !== 1'b1 || fault_code !== 2'b01 || busy !== 1'b0 || sp_level !== 4'd8 || ir_valid !== 1'b0) begin
      fails++;
      $display("FAIL overflow: got f=%0b code=%0b busy=%0b sp=%0d v=%0b want 1/01/0/8/0",
               fault, fault_code, busy, sp_level, ir_valid);
    end
    start = 1;
    step();
    start = 0;
    step();
    tests++;
    if (fault !== 1'b1 || busy !== 1'b0 || ir_valid !== 1'b0 || sp_level !== 4'd8) begin
      fails++;
      $display("FAIL fault_sticky: got f=%0b busy=%0b v=%0b sp=%0d want 1/0/0/8", fault, busy, ir_valid, sp_level);
    end
    ir_ready = 0;
    do_reset();
  endtask

  task automatic test_underflow();
    exp_q.push_back(11'd0);
    ir_ready = 1; start = 1;
    step();
    start = 0;
    step();
    br_ret = 1;
    step();
    br_ret = 0;
    tests++;
    if (fault !== 1'b1 || fault_code !== 2'b10 || busy !== 1'b0 || sp_level !== 4'd0 || ir_valid !== 1'b0) begin
      fails++;
      $display("FAIL underflow: got f=%0b code=%0b busy=%0b sp=%0d v=%0b want 1/10/0/0/0",
               fault, fault_code, busy, sp_level, ir_valid);
    end
    ir_ready = 0;
    do_reset();
  endtask

  task automatic test_wrap();
    exp_q.push_back(11'd0); exp_q.push_back(11'd2046); exp_q.push_back(11'd2047);
    ir_ready = 1; start = 1;
    step();
    start = 0;
    step();
    br_jump = 1; br_target = 11'd2046;
    step();
    br_jump = 0;
    step(); step();
    tests++;
    if (ir_pc !== 11'd2047 || ir !== rom_f(11'd2047) || rom_addr !== 11'd0) begin
      fails++;
      $display("FAIL wrap_top: got pc=%0d ir=%h addr=%0d want 2047/%h/0", ir_pc, ir, rom_addr, rom_f(11'd2047));
    end
    step();
    ir_ready = 0;
    tests++;
    if (ir_pc !== 11'd0 || ir !== 12'hA01 || ir_valid !== 1'b1) begin
      fails++;
      $display("FAIL wrap_zero: got pc=%0d ir=%h v=%0b want 0/a01/1", ir_pc, ir, ir_valid);
    end
  endtask

  task automatic test_halt_call();
    exp_q.push_back(11'd0); exp_q.push_back(11'd60);
    ir_ready = 1; br_call = 1; br_target = 11'd60;
    step();
    br_call = 0;
    step();   // ir_pc 60 presented, sp 1
    halt = 1; br_call = 1; br_target = 11'd90;
    step();
    halt = 0; br_call = 0;
    tests++;
    if (busy !== 1'b0 || ir_valid !== 1'b0 || sp_level !== 4'd1 || rom_addr !== 11'd61 || fault !== 1'b0) begin
      fails++;
      $display("FAIL halt_call: got busy=%0b v=%0b sp=%0d addr=%0d f=%0b want 0/0/1/61/0",
               busy, ir_valid, sp_level, rom_addr, fault);
    end
    start = 1;
    step();
    start = 0;
    step();
    tests++;
    if (busy !== 1'b0 || ir_valid !== 1'b0 || rom_addr !== 11'd61) begin
      fails++;
      $display("FAIL halt_sticky: got busy=%0b v=%0b addr=%0d want 0/0/61", busy, ir_valid, rom_addr);
    end
    ir_ready = 0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_backpressure();
    test_jump();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_wrap();
    test_halt_call();
    step();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: got %0d pending entries want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
